// File: rtl/lc3b_pipeline_sequencer_if.sv
// Sequencer handshake bundle: datapath/memory status in, stage-register controls and perf counters out.
// Combinational controls, no storage; the master side holds its inputs stable while the pipeline is frozen.
interface lc3b_pipeline_sequencer_if #(
    parameter int STALL_W = 16,
    parameter int FLUSH_W = 8
);
    logic               imem_req;
    logic               imem_resp;
    logic               dmem_req;
    logic               dmem_resp;
    logic               mem_indirect;
    logic               load_use_hazard;
    logic               branch_taken;
    logic               perf_clear;

    logic               load_pc;
    logic               load_if_id;
    logic               load_id_ex;
    logic               load_ex_mem;
    logic               load_mem_wb;
    logic               flush_if_id;
    logic               flush_id_ex;
    logic               flush_ex_mem;
    logic               pc_redirect;
    logic               mem_phase2;
    logic [STALL_W-1:0] stall_count;
    logic [FLUSH_W-1:0] flush_count;

    modport master (
        output imem_req, imem_resp, dmem_req, dmem_resp, mem_indirect,
               load_use_hazard, branch_taken, perf_clear,
        input  load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
               flush_if_id, flush_id_ex, flush_ex_mem, pc_redirect, mem_phase2,
               stall_count, flush_count
    );

    modport slave (
        input  imem_req, imem_resp, dmem_req, dmem_resp, mem_indirect,
               load_use_hazard, branch_taken, perf_clear,
        output load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
               flush_if_id, flush_id_ex, flush_ex_mem, pc_redirect, mem_phase2,
               stall_count, flush_count
    );
endinterface

// File: rtl/lc3b_pipeline_sequencer.sv
// LC-3b stall/flush sequencer: combinational stage loads/bubbles, same-edge effect, LDI/STI two-phase MEM.
// Backpressure: any outstanding memory wait freezes every stage register; saturating stall/flush counters.
module lc3b_pipeline_sequencer #(
    parameter int STALL_W = 16,
    parameter int FLUSH_W = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    lc3b_pipeline_sequencer_if.slave bus
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_IND2 = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic [FLUSH_W-1:0] flush_q, flush_d;

    logic fetch_ok;
    logic mem_ok;
    logic advance;
    logic go;

    always_comb begin
        fetch_ok = !bus.imem_req || bus.imem_resp;
        // First indirect access never completes MEM; only the pointer-phase response does.
        if (state_q == ST_IND2) begin
            mem_ok = bus.dmem_resp;
        end else begin
            mem_ok = !bus.dmem_req || (bus.dmem_resp && !bus.mem_indirect);
        end
        advance = fetch_ok && mem_ok;
        go      = advance && reset_n;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:  if (bus.dmem_req && bus.dmem_resp && bus.mem_indirect) state_d = ST_IND2;
            ST_IND2: if (advance) state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase

        stall_d = stall_q;
        if (bus.perf_clear) begin
            stall_d = '0;
        end else if (!advance && (stall_q != {STALL_W{1'b1}})) begin
            stall_d = stall_q + STALL_W'(1);
        end

        flush_d = flush_q;
        if (bus.perf_clear) begin
            flush_d = '0;
        end else if (advance && bus.branch_taken && (flush_q != {FLUSH_W{1'b1}})) begin
            flush_d = flush_q + FLUSH_W'(1);
        end
    end

    always_comb begin
        bus.load_pc      = 1'b0;
        bus.load_if_id   = 1'b0;
        bus.load_id_ex   = 1'b0;
        bus.load_ex_mem  = 1'b0;
        bus.load_mem_wb  = 1'b0;
        bus.flush_if_id  = 1'b0;
        bus.flush_id_ex  = 1'b0;
        bus.flush_ex_mem = 1'b0;
        bus.pc_redirect  = 1'b0;
        if (go) begin
            if (bus.branch_taken) begin
                bus.load_pc      = 1'b1;
                bus.load_if_id   = 1'b1;
                bus.load_id_ex   = 1'b1;
                bus.load_ex_mem  = 1'b1;
                bus.load_mem_wb  = 1'b1;
                bus.flush_if_id  = 1'b1;
                bus.flush_id_ex  = 1'b1;
                bus.flush_ex_mem = 1'b1;
                bus.pc_redirect  = 1'b1;
            end else if (bus.load_use_hazard) begin
                // Hold PC and IF/ID, slip a bubble into ID/EX behind the load.
                bus.load_id_ex   = 1'b1;
                bus.flush_id_ex  = 1'b1;
                bus.load_ex_mem  = 1'b1;
                bus.load_mem_wb  = 1'b1;
            end else begin
                bus.load_pc      = 1'b1;
                bus.load_if_id   = 1'b1;
                bus.load_id_ex   = 1'b1;
                bus.load_ex_mem  = 1'b1;
                bus.load_mem_wb  = 1'b1;
            end
        end
        bus.mem_phase2  = reset_n && (state_q == ST_IND2);
        bus.stall_count = stall_q;
        bus.flush_count = flush_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

endmodule

// File: tb/tb_lc3b_pipeline_sequencer.sv
// Bench for lc3b_pipeline_sequencer: vector table, hand-built corner sequences, then random traffic vs a model.
// Counter widths are narrowed so saturation is reachable in a few thousand cycles.
module tb_lc3b_pipeline_sequencer;

    localparam int SW = 12;
    localparam int FW = 4;

    // Output vector order: load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
    // flush_if_id, flush_id_ex, flush_ex_mem, pc_redirect, mem_phase2
    localparam logic [9:0] O_ALL = 10'b11111_000_0_0;
    localparam logic [9:0] O_BR  = 10'b11111_111_1_0;
    localparam logic [9:0] O_LU  = 10'b00111_010_0_0;
    localparam logic [9:0] O_FRZ = 10'b00000_000_0_0;
    localparam logic [9:0] O_P2  = 10'b00000_000_0_1;

    // Input vector order: imem_req, imem_resp, dmem_req, dmem_resp, mem_indirect, load_use_hazard, branch_taken
    localparam logic [6:0] I_IDLE = 7'b0000000;
    localparam logic [6:0] I_IW   = 7'b1000000;
    localparam logic [6:0] I_IOK  = 7'b1100000;
    localparam logic [6:0] I_LDIW = 7'b0010100;
    localparam logic [6:0] I_LDIR = 7'b0011100;

    typedef struct {
        logic [6:0] in;
        logic [9:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;
    int   nvec = 0;
    int   nmis = 0;
    vec_t tbl[16];

    always #5 clk = ~clk;

    lc3b_pipeline_sequencer_if #(.STALL_W(SW), .FLUSH_W(FW)) bus();

    lc3b_pipeline_sequencer #(.STALL_W(SW), .FLUSH_W(FW)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    function automatic logic [9:0] outs();
        return {bus.load_pc, bus.load_if_id, bus.load_id_ex, bus.load_ex_mem, bus.load_mem_wb,
                bus.flush_if_id, bus.flush_id_ex, bus.flush_ex_mem, bus.pc_redirect, bus.mem_phase2};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic [6:0] v, input logic clr);
        {bus.imem_req, bus.imem_resp, bus.dmem_req, bus.dmem_resp, bus.mem_indirect,
         bus.load_use_hazard, bus.branch_taken} = v;
        bus.perf_clear = clr;
    endtask

    // Entered and left at posedge+1; outputs sampled on the falling edge.
    task automatic step(input string name, input logic [6:0] v, input logic [9:0] exp);
        set_in(v, 1'b0);
        @(negedge clk);
        chk(name, 32'(outs()), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic run_cycles(input int n, input logic [6:0] v);
        set_in(v, 1'b0);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference: expected controls from the rules, given the current MEM phase.
    function automatic logic [9:0] model_outs(input logic [6:0] v, input bit ind2);
        bit ir, irs, dr, drs, ind, lu, br, fok, mok;
        logic [9:0] o;
        {ir, irs, dr, drs, ind, lu, br} = v;
        fok = !ir || irs;
        mok = ind2 ? drs : (!dr || (drs && !ind));
        if (!(fok && mok)) o = O_FRZ;
        else if (br)       o = O_BR;
        else if (lu)       o = O_LU;
        else               o = O_ALL;
        return o | (ind2 ? O_P2 : O_FRZ);
    endfunction

    initial begin
        bit         m_ind2;
        int         m_stall;
        int         m_flush;
        logic [6:0] v;
        logic       clr;
        logic [31:0] r;
        logic [9:0] o;

        tbl[0]  = '{7'b0000000, O_ALL};
        tbl[1]  = '{7'b1000000, O_FRZ};
        tbl[2]  = '{7'b1100000, O_ALL};
        tbl[3]  = '{7'b0010000, O_FRZ};
        tbl[4]  = '{7'b0011000, O_ALL};
        tbl[5]  = '{7'b0000001, O_BR};
        tbl[6]  = '{7'b0000010, O_LU};
        tbl[7]  = '{7'b0000011, O_BR};
        tbl[8]  = '{7'b1000001, O_FRZ};
        tbl[9]  = '{7'b0010010, O_FRZ};
        tbl[10] = '{7'b0010100, O_FRZ};
        tbl[11] = '{7'b1011100, O_FRZ};
        tbl[12] = '{7'b0010100, O_P2};
        tbl[13] = '{7'b1011100, O_P2};
        tbl[14] = '{7'b1111101, O_BR | O_P2};
        tbl[15] = '{7'b0000000, O_ALL};

        reset_n = 1'b0;
        set_in(I_IOK, 1'b0);
        #1;
        repeat (2) begin
            @(negedge clk);
            chk("reset_outs", 32'(outs()), 32'(O_FRZ));
        end
        chk("reset_stall", 32'(bus.stall_count), 0);
        chk("reset_flush", 32'(bus.flush_count), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) step("zero_wait", I_IOK, O_ALL);
        chk("zero_wait_stall", 32'(bus.stall_count), 0);

        for (int i = 0; i < 16; i++) step($sformatf("table_%0d", i), tbl[i].in, tbl[i].exp);
        chk("table_stall", 32'(bus.stall_count), 8);
        chk("table_flush", 32'(bus.flush_count), 3);

        for (int i = 0; i < 3; i++) step("imem_wait", I_IW, O_FRZ);
        step("imem_done", I_IOK, O_ALL);
        chk("imem_wait_stall", 32'(bus.stall_count), 11);

        step("ldi_c0", I_LDIW, O_FRZ);
        step("ldi_c1", I_LDIW, O_FRZ);
        step("ldi_c2", I_LDIR, O_FRZ);
        step("ldi_c3", I_LDIW, O_P2);
        step("ldi_c4", I_LDIW, O_P2);
        step("ldi_c5", I_LDIR, O_ALL | O_P2);
        step("ldi_after", I_IDLE, O_ALL);
        chk("ldi_stall", 32'(bus.stall_count), 16);

        step("load_use", 7'b0000010, O_LU);
        step("lu_gap", I_IDLE, O_ALL);
        step("lu_br_prio", 7'b0000011, O_BR);
        chk("lu_br_flush", 32'(bus.flush_count), 4);

        set_in(I_IW, 1'b1);
        @(posedge clk);
        #1;
        chk("clear_stall", 32'(bus.stall_count), 0);
        chk("clear_flush", 32'(bus.flush_count), 0);

        run_cycles((1 << SW) + 20, I_IW);
        chk("sat_stall", 32'(bus.stall_count), (1 << SW) - 1);
        run_cycles((1 << FW) + 4, 7'b0000001);
        chk("sat_flush", 32'(bus.flush_count), (1 << FW) - 1);
        set_in(I_IW, 1'b1);
        @(posedge clk);
        #1;
        chk("sat_clear_stall", 32'(bus.stall_count), 0);
        chk("sat_clear_flush", 32'(bus.flush_count), 0);

        step("to_ind2", I_LDIR, O_FRZ);
        set_in(I_LDIR, 1'b0);
        #2;
        chk("ind2_adv", 32'(outs()), 32'(O_ALL | O_P2));
        #1;
        reset_n = 1'b0;
        #1;
        chk("async_rst_outs", 32'(outs()), 32'(O_FRZ));
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        set_in(I_IDLE, 1'b0);
        @(negedge clk);
        chk("post_rst_run", 32'(outs()), 32'(O_ALL));
        @(posedge clk);
        #1;
        chk("post_rst_stall", 32'(bus.stall_count), 0);

        m_ind2  = 1'b0;
        m_stall = 0;
        m_flush = 0;
        for (int i = 0; i < 3000; i++) begin
            r   = $urandom;
            v   = {r[0], r[1] | r[2], r[3], r[4] | r[5], r[6], r[7] & r[8], r[9] & r[10]};
            clr = (r[15:11] == 5'd0);
            o   = model_outs(v, m_ind2);
            set_in(v, clr);
            @(negedge clk);
            chk("rand_outs", 32'(outs()), 32'(o));
            @(posedge clk);
            #1;
            if (clr) begin
                m_stall = 0;
                m_flush = 0;
            end else begin
                if (o[9:5] == 5'b0 && m_stall < (1 << SW) - 1) m_stall++;
                if (o[1] && m_flush < (1 << FW) - 1) m_flush++;
            end
            if (!m_ind2) m_ind2 = v[4] && v[3] && v[2];
            else if (o[9:5] != 5'b0) m_ind2 = 1'b0;
            chk("rand_stall", 32'(bus.stall_count), 32'(m_stall));
            chk("rand_flush", 32'(bus.flush_count), 32'(m_flush));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
